lookup_action_arbiter: RTL and testbench
========================================

Name: lookup_action_arbiter

Overview:
- Sits after the parallel lookup engines: vport default forwarding, exact-match table and wildcard table.
- Every engine answers each tuple exactly once, in tuple order, with its own latency.
- Per-engine FIFOs realign the answers so each tuple is evaluated once all engines have answered.
- Selects the highest-priority matching engine (lowest index) and emits one final action per tuple to the output-port logic, with backpressure.

Parameters:
C_NUM_ENGINES, 3, number of lookup engines; index 0 is highest priority (vport defaults).
C_OUT_PORT_WIDTH, 8, width of port/vport bitmaps.
C_MATCH_ADDR_WIDTH, 10, width of match address.
C_FIFO_DEPTH, 8, per-engine result FIFO depth and the maximum number of outstanding tuples; power of two, 2 or more.

Ports:
clk  in  1  single clock for the whole block.
reset  in  1  asynchronous, active-low reset.
tuple_valid  in  1  a tuple is issued to all engines this cycle.
tuple_ready  out  1  arbiter can accept another outstanding tuple.
eng_valid  in  C_NUM_ENGINES  per-engine action_valid.
eng_match  in  C_NUM_ENGINES  per-engine action_match.
eng_port  in  C_NUM_ENGINES*C_OUT_PORT_WIDTH  flattened action_port; engine i at slice i.
eng_vport  in  C_NUM_ENGINES*C_OUT_PORT_WIDTH  flattened action_vport.
eng_type  in  C_NUM_ENGINES*2  flattened action_type.
eng_match_addr  in  C_NUM_ENGINES*C_MATCH_ADDR_WIDTH  flattened match address.
final_valid  out  1  final action available.
final_ready  in  1  consumer accepts the final action.
final_match  out  1  at least one engine matched.
final_engine  out  $clog2(C_NUM_ENGINES)  index of the winning engine.
final_port  out  C_OUT_PORT_WIDTH  winning port bitmap.
final_vport  out  C_OUT_PORT_WIDTH  winning vport bitmap.
final_type  out  2  winning action type.
final_match_addr  out  C_MATCH_ADDR_WIDTH  winning match address.
overflow_err  out  1  sticky: an engine result arrived while its FIFO was full.
orphan_err  out  1  sticky: an engine result arrived with no tuple outstanding.
clear_err  in  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - all final_* outputs, overflow_err and orphan_err to 0;
  - the outstanding counter to 0;
  - all FIFOs to empty.
  - tuple_ready is therefore 1 after reset.
- Asserting reset mid-operation discards all queued results and the held final action; nothing is replayed after release.
- Outstanding counter (width $clog2(C_FIFO_DEPTH)+1):
  - +1 on tuple_valid && tuple_ready;
  - -1 on a pop;
  - simultaneous accept and pop leave it unchanged.
- tuple_ready = (outstanding < C_FIFO_DEPTH), combinational from the counter.
- tuple_valid while tuple_ready=0 is ignored and not counted; upstream must hold the tuple.
- Push:
  - eng_valid[i] writes engine i's {match, port, vport, type, addr} into FIFO i.
  - If FIFO i is full: drop the entry and set overflow_err.
  - If outstanding == 0 and no tuple is accepted in the same cycle: drop the entry and set orphan_err.
- Pop condition: all FIFOs non-empty AND (final_valid == 0 OR final_ready == 1).
  - On a pop, all FIFO heads are read in the same cycle and the output register is loaded.
- Selection:
  - Winner is the lowest index i whose head has match=1: final_match=1, final_engine=i, fields taken from engine i.
  - If no head matches: final_match=0, final_engine=0, port/vport/type/addr all 0.
- Output handshake:
  - final_valid rises on a pop.
  - While final_valid=1 and final_ready=0, all final_* outputs hold stable.
  - final_valid falls after a handshake if no new pop happens in that cycle.
  - Back-to-back pops give one result per cycle.
- Latency: if the last engine answering tuple n presents eng_valid in cycle T, final_valid for tuple n is high in cycle T+2, provided the output register is free.
- A FIFO push and pop in the same cycle are allowed, including when the FIFO is full (pop first frees the slot, so no overflow).
- FIFO pointers are $clog2(C_FIFO_DEPTH) bits plus a wrap bit; full = pointers equal with the wrap bits differing.
- clear_err has priority over setting an error in the same cycle.

Decomposition:
- Shared package (alongside parameters.v): C_OUT_PORT_WIDTH, C_MATCH_ADDR_WIDTH, and a packed struct action_t {match, port, vport, type, match_addr}.
- One sub-module, action_fifo: a synchronous FIFO of action_t with registered outputs, exposing empty/full, instantiated C_NUM_ENGINES times via generate.
- Priority selection and the output register stay in the top level.

Test Plan:
- Reset: release reset -> tuple_ready=1, final_valid=0, both error flags 0.
- Priority: one tuple; engine0 match=1 port=0x04; engine1 match=1 port=0x10; engine2 miss -> final_match=1, final_engine=0, final_port=0x04.
- Staggered latency and miss: engines answer at T, T+3, T+7, all miss -> final_valid high at T+9, final_match=0, all fields 0.
- Backpressure: final_ready=0 with 8 tuples issued and all engines answering -> tuple_ready=0 after the 8th accept, the held output stays stable, and the 9th tuple_valid is not counted. Release final_ready -> 8 results drain one per cycle, in order.
- Overflow: engine1 pushes 9 results with final_ready=0 -> overflow_err=1; clear_err -> 0.
- Orphan and reset mid-flight: eng_valid with no tuple outstanding -> orphan_err=1. Assert reset while 3 tuples are outstanding -> counter 0 and FIFOs empty after release.

Source files
------------

// File: rtl/lookup_action_arbiter_pkg.sv
// Shared widths and the per-engine action record carried through the result FIFOs.
package lookup_action_arbiter_pkg;

    localparam int C_OUT_PORT_WIDTH   = 8;
    localparam int C_MATCH_ADDR_WIDTH = 10;

    typedef struct packed {
        logic                          match;
        logic [C_OUT_PORT_WIDTH-1:0]   port;
        logic [C_OUT_PORT_WIDTH-1:0]   vport;
        logic [1:0]                    act_type;
        logic [C_MATCH_ADDR_WIDTH-1:0] match_addr;
    } action_t;

endpackage

// File: rtl/lookup_action_arbiter_action_fifo.sv
// Per-engine result FIFO: register array with wrap-bit pointers, head read straight from storage.
module lookup_action_arbiter_action_fifo
    import lookup_action_arbiter_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  action_t din,
    input  logic    pop,
    output action_t dout,
    output logic    empty,
    output logic    full
);

    localparam int PTR_W = $clog2(C_FIFO_DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    action_t        mem [C_FIFO_DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
    assign dout  = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Push while full is only issued together with a pop, which vacates this same slot.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/lookup_action_arbiter.sv
// Realigns per-engine lookup answers and emits one priority-selected action per tuple.
module lookup_action_arbiter
    import lookup_action_arbiter_pkg::*;
#(
    parameter int C_NUM_ENGINES = 3,
    parameter int C_FIFO_DEPTH  = 8
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            tuple_valid,
    output logic                                            tuple_ready,
    input  logic [C_NUM_ENGINES-1:0]                        eng_valid,
    input  logic [C_NUM_ENGINES-1:0]                        eng_match,
    input  logic [C_NUM_ENGINES*C_OUT_PORT_WIDTH-1:0]       eng_port,
    input  logic [C_NUM_ENGINES*C_OUT_PORT_WIDTH-1:0]       eng_vport,
    input  logic [C_NUM_ENGINES*2-1:0]                      eng_type,
    input  logic [C_NUM_ENGINES*C_MATCH_ADDR_WIDTH-1:0]     eng_match_addr,
    output logic                                            final_valid,
    input  logic                                            final_ready,
    output logic                                            final_match,
    output logic [((C_NUM_ENGINES > 1) ? $clog2(C_NUM_ENGINES) : 1)-1:0] final_engine,
    output logic [C_OUT_PORT_WIDTH-1:0]                     final_port,
    output logic [C_OUT_PORT_WIDTH-1:0]                     final_vport,
    output logic [1:0]                                      final_type,
    output logic [C_MATCH_ADDR_WIDTH-1:0]                   final_match_addr,
    output logic                                            overflow_err,
    output logic                                            orphan_err,
    input  logic                                            clear_err
);

    localparam int ENG_W = (C_NUM_ENGINES > 1) ? $clog2(C_NUM_ENGINES) : 1;
    localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
    localparam int PW    = C_OUT_PORT_WIDTH;
    localparam int AW    = C_MATCH_ADDR_WIDTH;

    logic [CNT_W-1:0]         outstanding;
    logic                     accept;
    logic                     pop;
    logic                     orphan_drop;
    logic [C_NUM_ENGINES-1:0] fifo_empty;
    logic [C_NUM_ENGINES-1:0] fifo_full;
    logic [C_NUM_ENGINES-1:0] fifo_push;
    logic [C_NUM_ENGINES-1:0] ovf_drop;
    action_t                  eng_act [C_NUM_ENGINES];
    action_t                  head    [C_NUM_ENGINES];
    action_t                  sel_act;
    logic [ENG_W-1:0]         sel_idx;

    assign tuple_ready = (outstanding < CNT_W'(C_FIFO_DEPTH));
    assign accept      = tuple_valid && tuple_ready;
    assign pop         = (~|fifo_empty) && (!final_valid || final_ready);
    // A same-cycle accept legitimises an answer arriving with zero latency.
    assign orphan_drop = (outstanding == '0) && !accept;

    for (genvar i = 0; i < C_NUM_ENGINES; i++) begin : g_eng
        assign eng_act[i] = '{
            match:      eng_match[i],
            port:       eng_port[i*PW +: PW],
            vport:      eng_vport[i*PW +: PW],
            act_type:   eng_type[i*2 +: 2],
            match_addr: eng_match_addr[i*AW +: AW]
        };
        assign fifo_push[i] = eng_valid[i] && !orphan_drop && (!fifo_full[i] || pop);
        assign ovf_drop[i]  = eng_valid[i] && !orphan_drop && fifo_full[i] && !pop;

        lookup_action_arbiter_action_fifo #(
            .C_FIFO_DEPTH(C_FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[i]),
            .din   (eng_act[i]),
            .pop   (pop),
            .dout  (head[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );
    end

    // Scan from the lowest-priority end so the lowest matching index wins.
    always_comb begin
        sel_act = '0;
        sel_idx = '0;
        for (int i = C_NUM_ENGINES - 1; i >= 0; i--) begin
            if (head[i].match) begin
                sel_act = head[i];
                sel_idx = ENG_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            final_valid      <= 1'b0;
            final_match      <= 1'b0;
            final_engine     <= '0;
            final_port       <= '0;
            final_vport      <= '0;
            final_type       <= '0;
            final_match_addr <= '0;
        end else if (pop) begin
            final_valid      <= 1'b1;
            final_match      <= sel_act.match;
            final_engine     <= sel_idx;
            final_port       <= sel_act.port;
            final_vport      <= sel_act.vport;
            final_type       <= sel_act.act_type;
            final_match_addr <= sel_act.match_addr;
        end else if (final_ready) begin
            final_valid      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding  <= '0;
            overflow_err <= 1'b0;
            orphan_err   <= 1'b0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (clear_err) begin
                overflow_err <= 1'b0;
                orphan_err   <= 1'b0;
            end else begin
                if (|ovf_drop)                  overflow_err <= 1'b1;
                if (orphan_drop && |eng_valid)  orphan_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lookup_action_arbiter.sv
// Scoreboard bench for lookup_action_arbiter: expected actions queued at stimulus, checked at handshake.
module tb_lookup_action_arbiter;

    localparam int NE = 3;
    localparam int PW = 8;
    localparam int AW = 10;

    typedef struct packed {
        logic          m;
        logic [1:0]    e;
        logic [PW-1:0] p;
        logic [PW-1:0] vp;
        logic [1:0]    t;
        logic [AW-1:0] a;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             tuple_valid;
    logic             tuple_ready;
    logic [NE-1:0]    eng_valid;
    logic [NE-1:0]    eng_match;
    logic [NE*PW-1:0] eng_port;
    logic [NE*PW-1:0] eng_vport;
    logic [NE*2-1:0]  eng_type;
    logic [NE*AW-1:0] eng_match_addr;
    logic             final_valid;
    logic             final_ready;
    logic             final_match;
    logic [1:0]       final_engine;
    logic [PW-1:0]    final_port;
    logic [PW-1:0]    final_vport;
    logic [1:0]       final_type;
    logic [AW-1:0]    final_match_addr;
    logic             overflow_err;
    logic             orphan_err;
    logic             clear_err;

    logic          am  [NE];
    logic [PW-1:0] ap  [NE];
    logic [PW-1:0] avp [NE];
    logic [1:0]    at  [NE];
    logic [AW-1:0] aa  [NE];

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    lookup_action_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .tuple_valid      (tuple_valid),
        .tuple_ready      (tuple_ready),
        .eng_valid        (eng_valid),
        .eng_match        (eng_match),
        .eng_port         (eng_port),
        .eng_vport        (eng_vport),
        .eng_type         (eng_type),
        .eng_match_addr   (eng_match_addr),
        .final_valid      (final_valid),
        .final_ready      (final_ready),
        .final_match      (final_match),
        .final_engine     (final_engine),
        .final_port       (final_port),
        .final_vport      (final_vport),
        .final_type       (final_type),
        .final_match_addr (final_match_addr),
        .overflow_err     (overflow_err),
        .orphan_err       (orphan_err),
        .clear_err        (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            eng_match[i]             = am[i];
            eng_port[i*PW +: PW]     = ap[i];
            eng_vport[i*PW +: PW]    = avp[i];
            eng_type[i*2 +: 2]       = at[i];
            eng_match_addr[i*AW +: AW] = aa[i];
        end
    end

    // Every accepted final action is compared against the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (reset && final_valid && final_ready) begin
            got = '{final_match, final_engine, final_port, final_vport, final_type, final_match_addr};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got %h, no result expected", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL sb_result: got %h, expected %h", got, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic exp_t model();
        exp_t r;
        r = '0;
        if (am[0])      r = '{1'b1, 2'd0, ap[0], avp[0], at[0], aa[0]};
        else if (am[1]) r = '{1'b1, 2'd1, ap[1], avp[1], at[1], aa[1]};
        else if (am[2]) r = '{1'b1, 2'd2, ap[2], avp[2], at[2], aa[2]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_eng(input int i, input logic m, input logic [PW-1:0] p,
                           input logic [PW-1:0] vp, input logic [1:0] t, input logic [AW-1:0] a);
        am[i] = m; ap[i] = p; avp[i] = vp; at[i] = t; aa[i] = a;
        eng_valid[i] = 1'b1;
    endtask

    task automatic issue_tuples(input int n);
        tuple_valid = 1'b1;
        repeat (n) tick();
        tuple_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (final_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        tuple_valid = 1'b0;
        eng_valid = '0;
        final_ready = 1'b1;
        clear_err = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (tuple_ready !== 1'b1 || final_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: tuple_ready=%b final_valid=%b, expected 1/0", tuple_ready, final_valid);
        end
        checks++;
        if ({overflow_err, orphan_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_errs: overflow=%b orphan=%b, expected 0/0", overflow_err, orphan_err);
        end
        checks++;
        if ({final_match, final_engine, final_port, final_vport, final_type, final_match_addr} !== '0) begin
            failures++;
            $display("FAIL reset_fields: match=%b eng=%0d port=%h, expected all 0", final_match, final_engine, final_port);
        end
        tick();
    endtask

    task automatic test_priority();
        bit ok;
        do_reset();
        issue_tuples(1);
        set_eng(0, 1'b1, 8'h04, 8'h01, 2'd1, 10'h011);
        set_eng(1, 1'b1, 8'h10, 8'h02, 2'd2, 10'h022);
        set_eng(2, 1'b0, 8'h40, 8'h04, 2'd3, 10'h033);
        sb.push_back(model());
        tick();
        eng_valid = '0;
        wait_valid(ok);
        checks++;
        if (!ok || final_match !== 1'b1 || final_engine !== 2'd0 || final_port !== 8'h04) begin
            failures++;
            $display("FAIL priority_e0: valid=%b match=%b eng=%0d port=%h, expected 1/1/0/04",
                     final_valid, final_match, final_engine, final_port);
        end
        tick();
        issue_tuples(1);
        set_eng(0, 1'b0, 8'h01, 8'h11, 2'd0, 10'h101);
        set_eng(1, 1'b1, 8'h20, 8'h22, 2'd2, 10'h202);
        set_eng(2, 1'b1, 8'h80, 8'h33, 2'd3, 10'h303);
        sb.push_back(model());
        tick();
        eng_valid = '0;
        wait_valid(ok);
        checks++;
        if (!ok || final_engine !== 2'd1 || final_port !== 8'h20 || final_match_addr !== 10'h202) begin
            failures++;
            $display("FAIL priority_e1: valid=%b eng=%0d port=%h addr=%h, expected 1/1/20/202",
                     final_valid, final_engine, final_port, final_match_addr);
        end
        tick();
    endtask

    task automatic test_staggered_miss();
        do_reset();
        issue_tuples(1);
        set_eng(0, 1'b0, 8'hAA, 8'h55, 2'd2, 10'h3FF);
        tick();
        eng_valid = '0;
        repeat (2) tick();
        set_eng(1, 1'b0, 8'hBB, 8'h66, 2'd1, 10'h2AA);
        tick();
        eng_valid = '0;
        repeat (3) tick();
        set_eng(2, 1'b0, 8'hCC, 8'h77, 2'd3, 10'h155);
        sb.push_back(model());
        tick();
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (final_valid !== 1'b0) begin
            failures++;
            $display("FAIL stagger_early: final_valid=%b at T+8, expected 0", final_valid);
        end
        @(negedge clk);
        checks++;
        if (final_valid !== 1'b1 || final_match !== 1'b0 || final_engine !== 2'd0 ||
            final_port !== 8'h00 || final_vport !== 8'h00 || final_type !== 2'd0 || final_match_addr !== 10'h000) begin
            failures++;
            $display("FAIL stagger_miss: valid=%b match=%b eng=%0d port=%h vport=%h type=%0d addr=%h, expected 1 and all 0",
                     final_valid, final_match, final_engine, final_port, final_vport, final_type, final_match_addr);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e0;
        exp_t got;
        do_reset();
        final_ready = 1'b0;
        issue_tuples(8);
        tuple_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (tuple_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_full: tuple_ready=%b after 8 accepts, expected 0", tuple_ready);
        end
        tick();
        tuple_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NE; i++)
                set_eng(i, k[i], 8'(k*16 + i), 8'(8'hF0 ^ (k*16 + i)), 2'(k + i), 10'(k*64 + i*8 + 1));
            sb.push_back(model());
            tick();
        end
        eng_valid = '0;
        e0 = sb[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = '{final_match, final_engine, final_port, final_vport, final_type, final_match_addr};
            checks++;
            if (final_valid !== 1'b1 || got !== e0) begin
                failures++;
                $display("FAIL bp_hold: valid=%b out=%h, expected 1 with %h", final_valid, got, e0);
            end
        end
        tick();
        final_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (final_valid !== 1'b1) begin
                failures++;
                $display("FAIL bp_drain_rate: final_valid=%b in drain cycle %0d, expected 1", final_valid, j);
            end
        end
        @(negedge clk);
        checks++;
        if (final_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL bp_drain_end: final_valid=%b pending=%0d, expected 0/0", final_valid, sb.size());
        end
        tick();
        set_eng(0, 1'b1, 8'h01, 8'h01, 2'd1, 10'h001);
        tick();
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (orphan_err !== 1'b1) begin
            failures++;
            $display("FAIL bp_ninth_not_counted: orphan_err=%b, expected 1", orphan_err);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        final_ready = 1'b0;
        issue_tuples(8);
        for (int k = 0; k < 8; k++) begin
            set_eng(1, 1'b1, 8'(k), 8'(k), 2'd1, 10'(k));
            tick();
        end
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_at_full: overflow_err=%b after 8 pushes, expected 0", overflow_err);
        end
        tick();
        set_eng(1, 1'b1, 8'h99, 8'h99, 2'd2, 10'h099);
        tick();
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b1 || orphan_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_ninth: overflow=%b orphan=%b, expected 1/0", overflow_err, orphan_err);
        end
        tick();
        clear_err = 1'b1;
        set_eng(1, 1'b1, 8'h9A, 8'h9A, 2'd2, 10'h09A);
        tick();
        clear_err = 1'b0;
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear_priority: overflow_err=%b, expected 0", overflow_err);
        end
        tick();
    endtask

    task automatic test_orphan_reset();
        bit ok;
        do_reset();
        set_eng(2, 1'b1, 8'h07, 8'h07, 2'd1, 10'h007);
        tick();
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (orphan_err !== 1'b1 || overflow_err !== 1'b0) begin
            failures++;
            $display("FAIL orphan_set: orphan=%b overflow=%b, expected 1/0", orphan_err, overflow_err);
        end
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if (orphan_err !== 1'b0) begin
            failures++;
            $display("FAIL orphan_clear: orphan_err=%b, expected 0", orphan_err);
        end
        tick();
        final_ready = 1'b0;
        issue_tuples(4);
        for (int i = 0; i < NE; i++) set_eng(i, 1'b1, 8'hE0, 8'hE1, 2'd3, 10'h0E0);
        tick();
        eng_valid = '0;
        for (int k = 0; k < 3; k++) begin
            set_eng(0, 1'b1, 8'hEE, 8'hEE, 2'd2, 10'h2EE);
            set_eng(1, 1'b1, 8'hDD, 8'hDD, 2'd1, 10'h1DD);
            tick();
        end
        eng_valid = '0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (final_valid !== 1'b0 || tuple_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_async: final_valid=%b tuple_ready=%b during reset, expected 0/1", final_valid, tuple_ready);
        end
        tick();
        reset = 1'b1;
        sb.delete();
        final_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (final_valid !== 1'b0 || tuple_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release: final_valid=%b tuple_ready=%b, expected 0/1", final_valid, tuple_ready);
        end
        tick();
        issue_tuples(1);
        set_eng(0, 1'b0, 8'h01, 8'h02, 2'd0, 10'h001);
        set_eng(1, 1'b0, 8'h03, 8'h04, 2'd0, 10'h002);
        set_eng(2, 1'b1, 8'h3C, 8'hC3, 2'd2, 10'h23C);
        sb.push_back(model());
        tick();
        eng_valid = '0;
        wait_valid(ok);
        checks++;
        if (!ok || final_engine !== 2'd2 || final_port !== 8'h3C) begin
            failures++;
            $display("FAIL rst_fifo_flushed: valid=%b eng=%0d port=%h, expected 1/2/3C", final_valid, final_engine, final_port);
        end
        tick();
        set_eng(1, 1'b1, 8'h05, 8'h05, 2'd1, 10'h005);
        tick();
        eng_valid = '0;
        @(negedge clk);
        checks++;
        if (orphan_err !== 1'b1 || final_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL rst_counter_zero: orphan=%b final_valid=%b pending=%0d, expected 1/0/0",
                     orphan_err, final_valid, sb.size());
        end
        tick();
    endtask

    initial begin
        reset = 1'b0;
        tuple_valid = 1'b0;
        eng_valid = '0;
        final_ready = 1'b1;
        clear_err = 1'b0;
        for (int i = 0; i < NE; i++) begin
            am[i] = 1'b0; ap[i] = '0; avp[i] = '0; at[i] = '0; aa[i] = '0;
        end
        test_reset();
        test_priority();
        test_staggered_miss();
        test_back_to_back();
        test_overflow();
        test_orphan_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
